// File: rtl/tile_router_sequencer_if.sv
// rtl/tile_router_sequencer_if.sv - control, router-programming and FIFO handshake bus of the tile router sequencer (o_stall_cycles present with ROUTER_PERF_CNT_EN)
interface tile_router_sequencer_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int ID_W       = 2,
   parameter int KR_W       = 2
);
   logic                  i_en;
   logic                  i_reg_clear;
   logic                  i_pop_en;
   logic                  i_conv_mode;
   logic [ADDR_WIDTH-1:0] i_start_addr;
   logic [ADDR_WIDTH-1:0] i_i_size;
   logic [ADDR_WIDTH-1:0] i_o_size;
   logic [ADDR_WIDTH-1:0] i_stride;
   logic [ADDR_WIDTH-1:0] i_i_c_size;
   logic [KR_W:0]         i_k_size;
   logic                  i_fifo_pop_ready;
   logic                  i_fifo_empty;
   logic [ID_W-1:0]       o_id;
   logic [KR_W-1:0]       o_k_row;
   logic [ADDR_WIDTH-1:0] o_start_addr;
   logic [ADDR_WIDTH-1:0] o_end_addr;
   logic                  o_addr_write_en;
   logic [ID_W:0]         o_group_count;
   logic                  o_route_en;
   logic                  o_pop_en;
   logic                  o_reg_clear;
   logic                  o_ready;
   logic                  o_done;
   logic                  o_context_done;
`ifdef ROUTER_PERF_CNT_EN
   logic [31:0]           o_stall_cycles;
`endif

   // sequencer side
   modport master (
      input  i_en, i_reg_clear, i_pop_en, i_conv_mode, i_start_addr, i_i_size,
             i_o_size, i_stride, i_i_c_size, i_k_size, i_fifo_pop_ready, i_fifo_empty,
      output o_id, o_k_row, o_start_addr, o_end_addr, o_addr_write_en, o_group_count,
             o_route_en, o_pop_en, o_reg_clear, o_ready, o_done, o_context_done
`ifdef ROUTER_PERF_CNT_EN
      , output o_stall_cycles
`endif
   );

   // upper control / tile reader side
   modport slave (
      output i_en, i_reg_clear, i_pop_en, i_conv_mode, i_start_addr, i_i_size,
             i_o_size, i_stride, i_i_c_size, i_k_size, i_fifo_pop_ready, i_fifo_empty,
      input  o_id, o_k_row, o_start_addr, o_end_addr, o_addr_write_en, o_group_count,
             o_route_en, o_pop_en, o_reg_clear, o_ready, o_done, o_context_done
`ifdef ROUTER_PERF_CNT_EN
      , input o_stall_cycles
`endif
   );
endinterface

// File: rtl/tile_router_sequencer.sv
// rtl/tile_router_sequencer.sv - walks the output map and programs NHWC address windows into routers per context (ROUTER_PERF_CNT_EN adds a CMP stall counter)
module tile_router_sequencer #(
   parameter int NUM_ROUTERS = 4,
   parameter int ADDR_WIDTH  = 8,
   parameter int MAX_K       = 3,
   parameter int ID_W        = (NUM_ROUTERS > 1) ? $clog2(NUM_ROUTERS) : 1,
   parameter int KR_W        = (MAX_K > 1) ? $clog2(MAX_K) : 1
) (
   input logic                     i_clk,
   input logic                     i_rst,
   tile_router_sequencer_if.master bus
);
   localparam int W2   = 2 * ADDR_WIDTH;
   localparam int KS_W = KR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_WRITE, S_STALL, S_CMP, S_DRAIN
   } state_t;

   state_t                state_q, state_d;

   // latched layer configuration
   logic [ADDR_WIDTH-1:0] cfg_base, cfg_w, cfg_o, cfg_s, cfg_c;
   logic [KS_W-1:0]       cfg_k;
   logic                  cfg_load;
   logic [KS_W-1:0]       k_in_eff;

   // write pointer: the pixel/row currently on the output bus
   logic [ADDR_WIDTH-1:0] ptr_r, ptr_c, ptr_r_d, ptr_c_d;
   logic [KR_W-1:0]       ptr_k, ptr_k_d;
   logic [ID_W-1:0]       ptr_id, ptr_id_d;
   logic                  xy_done_q, xy_done_d;

   // pointer advanced by one write
   logic [ADDR_WIDTH-1:0] adv_r, adv_c;
   logic [KR_W-1:0]       adv_k;
   logic [ID_W-1:0]       adv_id;
   logic                  k_last, c_last, r_last, pix_last, id_last, ctx_end;

   // address datapath source and results
   logic [ADDR_WIDTH-1:0] sel_r, sel_c;
   logic [KR_W-1:0]       sel_k;
   logic [W2-1:0]         row_w, pos_w, start_w, end_w;

   // registered outputs
   logic [ID_W-1:0]       id_q, id_d;
   logic [KR_W-1:0]       krow_q, krow_d;
   logic [ADDR_WIDTH-1:0] start_q, start_d, end_q, end_d;
   logic                  wr_q, wr_d;
   logic [ID_W:0]         gcnt_q, gcnt_d;
   logic                  route_q, route_d, pop_q, pop_d, clr_q, clr_d;
   logic                  ready_q, ready_d, done_q, done_d, cdone_q, cdone_d;

   // pointwise is a single-row kernel; K is kept within 1..MAX_K so k_row never overflows
   always_comb begin
      k_in_eff = bus.i_k_size;
      if (!bus.i_conv_mode || bus.i_k_size == '0)
         k_in_eff = KS_W'(1);
      else if (bus.i_k_size > KS_W'(MAX_K))
         k_in_eff = KS_W'(MAX_K);
   end

   // step the pointer: kernel row innermost, then column, then row
   always_comb begin
      k_last   = ({1'b0, ptr_k} + KS_W'(1)) == cfg_k;
      c_last   = ptr_c == cfg_o - ADDR_WIDTH'(1);
      r_last   = ptr_r == cfg_o - ADDR_WIDTH'(1);
      pix_last = k_last && c_last && r_last;
      id_last  = ptr_id == ID_W'(NUM_ROUTERS - 1);
      ctx_end  = k_last && (id_last || pix_last);
      adv_r    = ptr_r;
      adv_c    = ptr_c;
      adv_id   = ptr_id;
      adv_k    = k_last ? '0 : ptr_k + KR_W'(1);
      if (k_last) begin
         if (c_last) begin
            adv_c = '0;
            adv_r = ptr_r + ADDR_WIDTH'(1);
         end else begin
            adv_c = ptr_c + ADDR_WIDTH'(1);
         end
         adv_id = ctx_end ? '0 : ptr_id + ID_W'(1);
      end
   end

   // INIT presents the current pointer, WRITE presents the next one
   assign sel_r = (state_q == S_INIT) ? ptr_r : adv_r;
   assign sel_c = (state_q == S_INIT) ? ptr_c : adv_c;
   assign sel_k = (state_q == S_INIT) ? ptr_k : adv_k;

   // NHWC window at double width; truncation to ADDR_WIDTH happens at the register
   assign row_w   = W2'(sel_r) * W2'(cfg_s) + W2'(sel_k);
   assign pos_w   = (row_w * W2'(cfg_w) + W2'(sel_c) * W2'(cfg_s)) * W2'(cfg_c);
   assign start_w = W2'(cfg_base) + pos_w;
   assign end_w   = start_w + W2'(cfg_k) * W2'(cfg_c);

   // next state and next registered outputs
   always_comb begin
      state_d   = state_q;
      cfg_load  = 1'b0;
      ptr_r_d   = ptr_r;
      ptr_c_d   = ptr_c;
      ptr_k_d   = ptr_k;
      ptr_id_d  = ptr_id;
      xy_done_d = xy_done_q;
      id_d      = id_q;
      krow_d    = krow_q;
      start_d   = start_q;
      end_d     = end_q;
      wr_d      = 1'b0;
      gcnt_d    = gcnt_q;
      route_d   = route_q;
      pop_d     = pop_q;
      clr_d     = 1'b0;
      ready_d   = ready_q;
      done_d    = done_q;
      cdone_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.i_en && !done_q) begin
               state_d   = S_INIT;
               cfg_load  = 1'b1;
               ptr_r_d   = '0;
               ptr_c_d   = '0;
               ptr_k_d   = '0;
               ptr_id_d  = '0;
               xy_done_d = 1'b0;
            end
         end
         S_INIT: begin
            ready_d = 1'b0;
            gcnt_d  = '0;
            if (cfg_o == '0) begin
               xy_done_d = 1'b1;
               state_d   = S_STALL;
            end else begin
               wr_d    = 1'b1;
               id_d    = ptr_id;
               krow_d  = ptr_k;
               start_d = start_w[ADDR_WIDTH-1:0];
               end_d   = end_w[ADDR_WIDTH-1:0];
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            ptr_r_d  = adv_r;
            ptr_c_d  = adv_c;
            ptr_k_d  = adv_k;
            ptr_id_d = adv_id;
            if (ctx_end) begin
               gcnt_d    = {1'b0, ptr_id} + (ID_W + 1)'(1);
               xy_done_d = pix_last;
               state_d   = S_STALL;
            end else begin
               wr_d    = 1'b1;
               id_d    = adv_id;
               krow_d  = adv_k;
               start_d = start_w[ADDR_WIDTH-1:0];
               end_d   = end_w[ADDR_WIDTH-1:0];
            end
         end
         S_STALL: begin
            route_d = 1'b1;
            state_d = S_CMP;
         end
         S_CMP: begin
            if (bus.i_fifo_pop_ready) begin
               route_d = 1'b0;
               ready_d = 1'b1;
               pop_d   = 1'b1;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (bus.i_fifo_empty) begin
               pop_d   = 1'b0;
               ready_d = 1'b0;
               clr_d   = 1'b1;
               if (xy_done_q) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  cdone_d = 1'b1;
                  state_d = S_INIT;
               end
            end else begin
               pop_d = bus.i_pop_en;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state, pointer and output registers; reset and soft clear behave identically
   always_ff @(posedge i_clk) begin
      if (i_rst || bus.i_reg_clear) begin
         state_q   <= S_IDLE;
         ptr_r     <= '0;
         ptr_c     <= '0;
         ptr_k     <= '0;
         ptr_id    <= '0;
         xy_done_q <= 1'b0;
         id_q      <= '0;
         krow_q    <= '0;
         start_q   <= '0;
         end_q     <= '0;
         wr_q      <= 1'b0;
         gcnt_q    <= '0;
         route_q   <= 1'b0;
         pop_q     <= 1'b0;
         clr_q     <= 1'b0;
         ready_q   <= 1'b0;
         done_q    <= 1'b0;
         cdone_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_r     <= ptr_r_d;
         ptr_c     <= ptr_c_d;
         ptr_k     <= ptr_k_d;
         ptr_id    <= ptr_id_d;
         xy_done_q <= xy_done_d;
         id_q      <= id_d;
         krow_q    <= krow_d;
         start_q   <= start_d;
         end_q     <= end_d;
         wr_q      <= wr_d;
         gcnt_q    <= gcnt_d;
         route_q   <= route_d;
         pop_q     <= pop_d;
         clr_q     <= clr_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
         cdone_q   <= cdone_d;
      end
   end

   // configuration is captured only when a layer starts
   always_ff @(posedge i_clk) begin
      if (i_rst || bus.i_reg_clear) begin
         cfg_base <= '0;
         cfg_w    <= '0;
         cfg_o    <= '0;
         cfg_s    <= '0;
         cfg_c    <= '0;
         cfg_k    <= '0;
      end else if (cfg_load) begin
         cfg_base <= bus.i_start_addr;
         cfg_w    <= bus.i_i_size;
         cfg_o    <= bus.i_o_size;
         cfg_s    <= bus.i_stride;
         cfg_c    <= bus.i_i_c_size;
         cfg_k    <= k_in_eff;
      end
   end

`ifdef ROUTER_PERF_CNT_EN
   logic [31:0] stall_q;

   // saturating count of CMP cycles spent waiting on the tile FIFO
   always_ff @(posedge i_clk) begin
      if (i_rst || bus.i_reg_clear)
         stall_q <= '0;
      else if (state_q == S_CMP && !bus.i_fifo_pop_ready && stall_q != '1)
         stall_q <= stall_q + 32'd1;
   end

   assign bus.o_stall_cycles = stall_q;
`endif

   assign bus.o_id            = id_q;
   assign bus.o_k_row         = krow_q;
   assign bus.o_start_addr    = start_q;
   assign bus.o_end_addr      = end_q;
   assign bus.o_addr_write_en = wr_q;
   assign bus.o_group_count   = gcnt_q;
   assign bus.o_route_en      = route_q;
   assign bus.o_pop_en        = pop_q;
   assign bus.o_reg_clear     = clr_q;
   assign bus.o_ready         = ready_q;
   assign bus.o_done          = done_q;
   assign bus.o_context_done  = cdone_q;
endmodule

// File: tb/tb_tile_router_sequencer.sv
// tb/tb_tile_router_sequencer.sv - directed self-checking bench for tile_router_sequencer
module tb_tile_router_sequencer;
   localparam int AW   = 8;
   localparam int ID_W = 2;
   localparam int KR_W = 2;
   localparam int OUTW = ID_W + KR_W + 2 * AW + 1 + (ID_W + 1) + 6;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   int   wr_id[$], wr_k[$], wr_s[$], wr_e[$], wr_cyc[$], grp[$];
   int   n_cdone;
   bit   got_done;
   bit   timed_out;

   tile_router_sequencer_if #(.ADDR_WIDTH(AW), .ID_W(ID_W), .KR_W(KR_W)) bus();

   tile_router_sequencer #(
      .NUM_ROUTERS(4), .ADDR_WIDTH(AW), .MAX_K(3)
   ) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus.master)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [OUTW-1:0] out_vec();
      return {bus.o_id, bus.o_k_row, bus.o_start_addr, bus.o_end_addr, bus.o_addr_write_en,
              bus.o_group_count, bus.o_route_en, bus.o_pop_en, bus.o_reg_clear,
              bus.o_ready, bus.o_done, bus.o_context_done};
   endfunction

   task automatic idle_inputs();
      bus.i_en = 0; bus.i_reg_clear = 0; bus.i_pop_en = 1;
      bus.i_fifo_pop_ready = 0; bus.i_fifo_empty = 0;
   endtask

   task automatic configure(input int mode, input int base, input int isz, input int osz,
                            input int s, input int c, input int k);
      bus.i_conv_mode  = mode[0];
      bus.i_start_addr = AW'(base);
      bus.i_i_size     = AW'(isz);
      bus.i_o_size     = AW'(osz);
      bus.i_stride     = AW'(s);
      bus.i_i_c_size   = AW'(c);
      bus.i_k_size     = (KR_W + 1)'(k);
   endtask

   task automatic soft_clear();
      @(negedge i_clk); bus.i_reg_clear = 1;
      @(negedge i_clk); bus.i_reg_clear = 0;
   endtask

   task automatic start_layer();
      @(negedge i_clk); bus.i_en = 1;
      @(negedge i_clk); bus.i_en = 0;
   endtask

   task automatic clear_log();
      wr_id.delete(); wr_k.delete(); wr_s.delete(); wr_e.delete(); wr_cyc.delete(); grp.delete();
      n_cdone = 0; got_done = 0; timed_out = 0;
   endtask

   // tile reader model: pop_ready follows route_en, FIFO empties on the third drain cycle
   task automatic run_layer(input int max_cycles);
      int cyc = 0;
      int dcnt = 0;
      while (!got_done) begin
         @(negedge i_clk);
         cyc++;
         if (cyc > max_cycles) begin
            timed_out = 1;
            break;
         end
         if (bus.o_addr_write_en) begin
            wr_id.push_back(int'(bus.o_id)); wr_k.push_back(int'(bus.o_k_row));
            wr_s.push_back(int'(bus.o_start_addr)); wr_e.push_back(int'(bus.o_end_addr));
            wr_cyc.push_back(cyc);
         end
         if (bus.o_context_done) n_cdone++;
         if (bus.o_done) got_done = 1;
         bus.i_fifo_pop_ready = bus.o_route_en;
         if (bus.o_ready) begin
            dcnt++;
            if (dcnt == 1) grp.push_back(int'(bus.o_group_count));
            bus.i_fifo_empty = (dcnt >= 3);
         end else begin
            dcnt = 0;
            bus.i_fifo_empty = 0;
         end
      end
      bus.i_fifo_pop_ready = 0;
      bus.i_fifo_empty = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      configure(0, 0, 4, 4, 1, 8, 0);
      i_rst = 1;
      repeat (2) @(negedge i_clk);
      i_rst = 0;
      vectors++;
      if (out_vec() !== '0) begin
         $display("FAIL reset_outputs: got %h want 0", out_vec()); miscompares++;
      end
`ifdef ROUTER_PERF_CNT_EN
      vectors++;
      if (bus.o_stall_cycles !== 32'd0) begin
         $display("FAIL reset_stall: got %0d want 0", bus.o_stall_cycles); miscompares++;
      end
`endif
      repeat (2) @(negedge i_clk);
      vectors++;
      if (out_vec() !== '0) begin
         $display("FAIL idle_no_start: got %h want 0", out_vec()); miscompares++;
      end
   endtask

   task automatic test_pointwise();
      soft_clear();
      clear_log();
      configure(0, 0, 4, 4, 1, 8, 0);
      start_layer();
      run_layer(500);
      vectors++;
      if (timed_out || !got_done) begin
         $display("FAIL pw_done: got 0 want 1"); miscompares++;
      end
      vectors++;
      if (wr_s.size() != 16) begin
         $display("FAIL pw_write_count: got %0d want 16", wr_s.size()); miscompares++;
      end
      for (int i = 0; i < 16 && i < wr_s.size(); i++) begin
         vectors++;
         if (wr_id[i] != i % 4 || wr_k[i] != 0 || wr_s[i] != 8 * i || wr_e[i] != 8 * i + 8) begin
            $display("FAIL pw_write%0d: got id%0d k%0d (%0d,%0d) want id%0d k0 (%0d,%0d)",
                     i, wr_id[i], wr_k[i], wr_s[i], wr_e[i], i % 4, 8 * i, 8 * i + 8);
            miscompares++;
         end
      end
      if (wr_cyc.size() >= 4) begin
         vectors++;
         if (wr_cyc[3] - wr_cyc[0] != 3) begin
            $display("FAIL pw_back_to_back: got span %0d want 3", wr_cyc[3] - wr_cyc[0]);
            miscompares++;
         end
      end
      vectors++;
      if (n_cdone != 3) begin
         $display("FAIL pw_context_done: got %0d want 3", n_cdone); miscompares++;
      end
      vectors++;
      if (grp.size() != 4) begin
         $display("FAIL pw_contexts: got %0d want 4", grp.size()); miscompares++;
      end
      for (int i = 0; i < grp.size(); i++) begin
         vectors++;
         if (grp[i] != 4) begin
            $display("FAIL pw_group%0d: got %0d want 4", i, grp[i]); miscompares++;
         end
      end
   endtask

   task automatic test_depthwise();
      int exp_s[12];
      exp_s = '{16, 40, 64, 24, 48, 72, 64, 88, 112, 72, 96, 120};
      soft_clear();
      clear_log();
      configure(1, 16, 6, 2, 2, 4, 3);
      start_layer();
      run_layer(500);
      vectors++;
      if (timed_out || !got_done) begin
         $display("FAIL dw_done: got 0 want 1"); miscompares++;
      end
      vectors++;
      if (wr_s.size() != 12) begin
         $display("FAIL dw_write_count: got %0d want 12", wr_s.size()); miscompares++;
      end
      for (int i = 0; i < 12 && i < wr_s.size(); i++) begin
         vectors++;
         if (wr_id[i] != i / 3 || wr_k[i] != i % 3 || wr_s[i] != exp_s[i] || wr_e[i] != exp_s[i] + 12) begin
            $display("FAIL dw_write%0d: got id%0d k%0d (%0d,%0d) want id%0d k%0d (%0d,%0d)",
                     i, wr_id[i], wr_k[i], wr_s[i], wr_e[i], i / 3, i % 3, exp_s[i], exp_s[i] + 12);
            miscompares++;
         end
      end
      vectors++;
      if (n_cdone != 0) begin
         $display("FAIL dw_context_done: got %0d want 0", n_cdone); miscompares++;
      end
      vectors++;
      if (grp.size() != 1 || (grp.size() == 1 && grp[0] != 4)) begin
         $display("FAIL dw_group: got %0d contexts want 1 with 4 routers", grp.size()); miscompares++;
      end
   endtask

   task automatic test_partial();
      int exp_g[3];
      exp_g = '{4, 4, 1};
      soft_clear();
      clear_log();
      configure(0, 0, 3, 3, 1, 8, 0);
      start_layer();
      run_layer(500);
      vectors++;
      if (timed_out || !got_done) begin
         $display("FAIL part_done: got 0 want 1"); miscompares++;
      end
      vectors++;
      if (grp.size() != 3) begin
         $display("FAIL part_contexts: got %0d want 3", grp.size()); miscompares++;
      end
      for (int i = 0; i < 3 && i < grp.size(); i++) begin
         vectors++;
         if (grp[i] != exp_g[i]) begin
            $display("FAIL part_group%0d: got %0d want %0d", i, grp[i], exp_g[i]); miscompares++;
         end
      end
      vectors++;
      if (wr_s.size() != 9) begin
         $display("FAIL part_write_count: got %0d want 9", wr_s.size()); miscompares++;
      end else begin
         vectors++;
         if (wr_id[8] != 0 || wr_s[8] != 64 || wr_e[8] != 72) begin
            $display("FAIL part_last_write: got id%0d (%0d,%0d) want id0 (64,72)", wr_id[8], wr_s[8], wr_e[8]);
            miscompares++;
         end
      end
      vectors++;
      if (n_cdone != 2) begin
         $display("FAIL part_context_done: got %0d want 2", n_cdone); miscompares++;
      end
   endtask

   task automatic test_empty_layer();
      soft_clear();
      clear_log();
      configure(0, 0, 4, 0, 1, 8, 0);
      start_layer();
      run_layer(200);
      vectors++;
      if (timed_out || !got_done) begin
         $display("FAIL empty_done: got 0 want 1"); miscompares++;
      end
      vectors++;
      if (wr_s.size() != 0) begin
         $display("FAIL empty_writes: got %0d want 0", wr_s.size()); miscompares++;
      end
      vectors++;
      if (grp.size() != 1 || (grp.size() == 1 && grp[0] != 0)) begin
         $display("FAIL empty_group: got %0d contexts want 1 with 0 routers", grp.size()); miscompares++;
      end
   endtask

   task automatic test_fifo_stall();
      soft_clear();
      configure(0, 0, 1, 1, 1, 8, 0);
      bus.i_pop_en = 1;
      bus.i_fifo_empty = 0;
      bus.i_fifo_pop_ready = 0;
      start_layer();
      for (int n = 0; n < 20 && !bus.o_route_en; n++) @(negedge i_clk);
      vectors++;
      if (!bus.o_route_en) begin
         $display("FAIL stall_route_timeout: got 0 want 1"); miscompares++;
         return;
      end
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (bus.o_route_en !== 1'b1 || bus.o_ready !== 1'b0) begin
            $display("FAIL stall_cycle%0d: got route %0b ready %0b want route 1 ready 0",
                     i, bus.o_route_en, bus.o_ready);
            miscompares++;
         end
         @(negedge i_clk);
      end
      bus.i_fifo_pop_ready = 1;
      @(negedge i_clk);
      bus.i_fifo_pop_ready = 0;
      vectors++;
      if (bus.o_ready !== 1'b1 || bus.o_pop_en !== 1'b1 || bus.o_route_en !== 1'b0) begin
         $display("FAIL stall_release: got ready %0b pop %0b route %0b want 1 1 0",
                  bus.o_ready, bus.o_pop_en, bus.o_route_en);
         miscompares++;
      end
`ifdef ROUTER_PERF_CNT_EN
      vectors++;
      if (bus.o_stall_cycles !== 32'd5) begin
         $display("FAIL stall_count: got %0d want 5", bus.o_stall_cycles); miscompares++;
      end
`endif
   endtask

   task automatic test_drain_backpressure();
      int seq[3];
      seq = '{1, 0, 1};
      for (int i = 0; i < 3; i++) begin
         bus.i_pop_en = seq[i][0];
         @(negedge i_clk);
         vectors++;
         if (bus.o_pop_en !== seq[i][0]) begin
            $display("FAIL drain_pop%0d: got %0b want %0d", i, bus.o_pop_en, seq[i]); miscompares++;
         end
      end
      bus.i_fifo_empty = 1;
      @(negedge i_clk);
      bus.i_fifo_empty = 0;
      vectors++;
      if (bus.o_pop_en !== 1'b0 || bus.o_ready !== 1'b0 || bus.o_reg_clear !== 1'b1 ||
          bus.o_done !== 1'b1 || bus.o_context_done !== 1'b0) begin
         $display("FAIL drain_end: got pop %0b ready %0b clr %0b done %0b cdone %0b want 0 0 1 1 0",
                  bus.o_pop_en, bus.o_ready, bus.o_reg_clear, bus.o_done, bus.o_context_done);
         miscompares++;
      end
      bus.i_pop_en = 1;
      bus.i_en = 1;
      @(negedge i_clk);
      bus.i_en = 0;
      vectors++;
      if (bus.o_reg_clear !== 1'b0 || bus.o_done !== 1'b1) begin
         $display("FAIL drain_clear_pulse: got clr %0b done %0b want 0 1", bus.o_reg_clear, bus.o_done);
         miscompares++;
      end
      repeat (2) @(negedge i_clk);
      vectors++;
      if (bus.o_addr_write_en !== 1'b0 || bus.o_done !== 1'b1) begin
         $display("FAIL done_ignores_en: got wr %0b done %0b want 0 1", bus.o_addr_write_en, bus.o_done);
         miscompares++;
      end
   endtask

   task automatic test_mid_reset();
      soft_clear();
      configure(0, 0, 4, 4, 1, 8, 0);
      bus.i_fifo_empty = 0;
      start_layer();
      for (int n = 0; n < 50 && !bus.o_ready; n++) begin
         @(negedge i_clk);
         bus.i_fifo_pop_ready = bus.o_route_en;
      end
      bus.i_fifo_pop_ready = 0;
      vectors++;
      if (!bus.o_ready) begin
         $display("FAIL mid_reach_drain: got 0 want 1"); miscompares++;
      end
      i_rst = 1;
      @(negedge i_clk);
      i_rst = 0;
      vectors++;
      if (out_vec() !== '0) begin
         $display("FAIL rst_in_drain: got %h want 0", out_vec()); miscompares++;
      end
      repeat (2) @(negedge i_clk);
      vectors++;
      if (out_vec() !== '0) begin
         $display("FAIL rst_stays_idle: got %h want 0", out_vec()); miscompares++;
      end
      start_layer();
      @(negedge i_clk);
      vectors++;
      if (bus.o_addr_write_en !== 1'b1 || bus.o_id !== 2'd0 || bus.o_start_addr !== 8'd0 || bus.o_end_addr !== 8'd8) begin
         $display("FAIL restart_after_rst: got wr %0b id %0d (%0d,%0d) want 1 0 (0,8)",
                  bus.o_addr_write_en, bus.o_id, bus.o_start_addr, bus.o_end_addr);
         miscompares++;
      end
      @(negedge i_clk);
      bus.i_reg_clear = 1;
      @(negedge i_clk);
      bus.i_reg_clear = 0;
      vectors++;
      if (out_vec() !== '0) begin
         $display("FAIL clear_in_write: got %h want 0", out_vec()); miscompares++;
      end
      start_layer();
      @(negedge i_clk);
      vectors++;
      if (bus.o_addr_write_en !== 1'b1 || bus.o_id !== 2'd0 || bus.o_start_addr !== 8'd0 || bus.o_end_addr !== 8'd8) begin
         $display("FAIL restart_after_clear: got wr %0b id %0d (%0d,%0d) want 1 0 (0,8)",
                  bus.o_addr_write_en, bus.o_id, bus.o_start_addr, bus.o_end_addr);
         miscompares++;
      end
   endtask

   initial begin
      test_reset();
      test_pointwise();
      test_depthwise();
      test_partial();
      test_empty_layer();
      test_fifo_stall();
      test_drain_backpressure();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
